// File: rtl/control_carga_if.sv
// control_carga_if: control and status bundle of the two-battery charge controller.
//   master: drives habilitar / descarga1 / descarga2 and observes the status.
//   slave : the controller; samples the controls and drives the status.
//   habilitar       charger enable (level)
//   descarga1/2     one-cycle discharge pulse for battery 1 / 2
//   carga_bateria*  4-bit charge level of each battery
//   carga_total     5-bit sum of both levels
//   cargando        charger active
//   sel_bateria     0 = battery 1 is being charged, 1 = battery 2
//   bateria_baja    pack total below the low threshold
//   completo        pack full
interface control_carga_if;
    logic       habilitar;
    logic       descarga1;
    logic       descarga2;
    logic [3:0] carga_bateria1;
    logic [3:0] carga_bateria2;
    logic [4:0] carga_total;
    logic       cargando;
    logic       sel_bateria;
    logic       bateria_baja;
    logic       completo;

    modport master (
        output habilitar, descarga1, descarga2,
        input  carga_bateria1, carga_bateria2, carga_total,
               cargando, sel_bateria, bateria_baja, completo
    );

    modport slave (
        input  habilitar, descarga1, descarga2,
        output carga_bateria1, carga_bateria2, carga_total,
               cargando, sel_bateria, bateria_baja, completo
    );
endinterface

// File: rtl/control_carga.sv
// control_carga: shares one charger between two 4-bit batteries.
//   The charger is re-arbitrated before every +1 step, always toward the
//   emptier battery (ties go opposite the last-served battery). Discharge
//   pulses apply in every state and saturate at 0. Charging stops when the
//   pack reaches 15/15 or when habilitar drops.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    control_carga_if.slave (controls in, levels/status out)
// Parameters:
//   TICKS_POR_PASO  CARGAR cycles per +1 step (>= 1)
//   UMBRAL_TOTAL    low-pack threshold on carga_total
module control_carga #(
    parameter int         TICKS_POR_PASO = 4,
    parameter logic [4:0] UMBRAL_TOTAL   = 5'd8
) (
    input  logic               clk,
    input  logic               rst_n,
    control_carga_if.slave     bus
);
    localparam int CW = (TICKS_POR_PASO > 1) ? $clog2(TICKS_POR_PASO) : 1;
    localparam logic [CW-1:0] CNT_FIN = CW'(TICKS_POR_PASO - 1);
    localparam logic [4:0]    TOTAL_LLENO = 5'd30;

    typedef enum logic [1:0] {REPOSO, ELEGIR, CARGAR, LLENO} estado_t;

    estado_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    lvl1_q, lvl1_d, lvl2_q, lvl2_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;

    logic [4:0] total_q, total_d;
    logic       paso, inc1, inc2;

    assign total_q = {1'b0, lvl1_q} + {1'b0, lvl2_q};
    assign total_d = {1'b0, lvl1_d} + {1'b0, lvl2_d};

    // A step completes only on the terminal count with the enable still high.
    assign paso = (state_q == CARGAR) && bus.habilitar && (cnt_q == CNT_FIN);
    assign inc1 = paso && !sel_q;
    assign inc2 = paso &&  sel_q;

    // Levels: an increment and a discharge on the same battery cancel out.
    always_comb begin
        lvl1_d = lvl1_q;
        lvl2_d = lvl2_q;
        if (inc1 && !bus.descarga1)                        lvl1_d = lvl1_q + 4'd1;
        else if (!inc1 && bus.descarga1 && lvl1_q != 4'd0) lvl1_d = lvl1_q - 4'd1;
        if (inc2 && !bus.descarga2)                        lvl2_d = lvl2_q + 4'd1;
        else if (!inc2 && bus.descarga2 && lvl2_q != 4'd0) lvl2_d = lvl2_q - 4'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            REPOSO: begin
                if (bus.habilitar)
                    state_d = (total_q == TOTAL_LLENO) ? LLENO : ELEGIR;
            end
            ELEGIR: begin
                if (!bus.habilitar) begin
                    state_d = REPOSO;
                end else begin
                    if (lvl1_q < lvl2_q)      sel_d = 1'b0;
                    else if (lvl2_q < lvl1_q) sel_d = 1'b1;
                    else                      sel_d = ~last_q;
                    last_d  = sel_d;
                    cnt_d   = '0;
                    state_d = CARGAR;
                end
            end
            CARGAR: begin
                if (!bus.habilitar) begin
                    // Partial step is abandoned.
                    cnt_d   = '0;
                    state_d = REPOSO;
                end else if (cnt_q == CNT_FIN) begin
                    cnt_d   = '0;
                    state_d = (total_d == TOTAL_LLENO) ? LLENO : ELEGIR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LLENO: begin
                if (total_q < TOTAL_LLENO) state_d = REPOSO;
            end
            default: state_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REPOSO;
            cnt_q   <= '0;
            lvl1_q  <= 4'd0;
            lvl2_q  <= 4'd0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl1_q  <= lvl1_d;
            lvl2_q  <= lvl2_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign bus.carga_bateria1 = lvl1_q;
    assign bus.carga_bateria2 = lvl2_q;
    assign bus.carga_total    = total_q;
    assign bus.cargando       = (state_q == CARGAR);
    assign bus.sel_bateria    = sel_q;
    assign bus.bateria_baja   = (total_q < UMBRAL_TOTAL);
    assign bus.completo       = (state_q == LLENO);
endmodule

// File: tb/tb_control_carga.sv
// tb_control_carga: directed timing checks plus a long randomized run of
// control_carga, compared every cycle against a behavioural pack model.
module tb_control_carga;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n;
    control_carga_if bus();

    control_carga #(.TICKS_POR_PASO(T), .UMBRAL_TOTAL(5'd8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: pack levels plus what the charger is doing.
    // mode: 0 idle, 1 choosing, 2 charging (age = cycles spent in step), 3 full
    int  b[2];
    int  mode, age, tgt, last_srv;

    task automatic m_reset();
        b[0] = 0; b[1] = 0;
        mode = 0; age = 0; tgt = 0; last_srv = 1;
    endtask

    task automatic m_step(input bit hab, input bit d1, input bit d2);
        int  nb[2];
        bit  d[2];
        bit  step_done;
        int  tot;
        d[0] = d1; d[1] = d2;
        tot = b[0] + b[1];
        step_done = (mode == 2) && hab && (age == T - 1);
        for (int i = 0; i < 2; i++) begin
            nb[i] = b[i];
            if (step_done && tgt == i) nb[i] = d[i] ? b[i] : b[i] + 1;
            else if (d[i] && b[i] > 0) nb[i] = b[i] - 1;
        end
        case (mode)
            0: if (hab) mode = (tot == 30) ? 3 : 1;
            1: if (!hab) mode = 0;
               else begin
                   if (b[0] != b[1]) tgt = (b[0] < b[1]) ? 0 : 1;
                   else              tgt = 1 - last_srv;
                   last_srv = tgt;
                   age  = 0;
                   mode = 2;
               end
            2: if (!hab) begin mode = 0; age = 0; end
               else if (step_done) begin
                   age  = 0;
                   mode = (nb[0] + nb[1] == 30) ? 3 : 1;
               end else age++;
            default: if (tot < 30) mode = 0;
        endcase
        b[0] = nb[0]; b[1] = nb[1];
    endtask

    task automatic cmp_all();
        chk("lvl1",  int'(bus.carga_bateria1), b[0]);
        chk("lvl2",  int'(bus.carga_bateria2), b[1]);
        chk("total", int'(bus.carga_total),    b[0] + b[1]);
        chk("baja",  int'(bus.bateria_baja),   int'((b[0] + b[1]) < 8));
        chk("carg",  int'(bus.cargando),       int'(mode == 2));
        chk("comp",  int'(bus.completo),       int'(mode == 3));
        if (mode == 2) chk("sel", int'(bus.sel_bateria), tgt);
    endtask

    // One clock edge: model advances on the same inputs the DUT samples.
    task automatic tick();
        @(posedge clk);
        m_step(bus.habilitar, bus.descarga1, bus.descarga2);
        #1;
        cmp_all();
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        bus.habilitar = 1'b0; bus.descarga1 = 1'b0; bus.descarga2 = 1'b0;
        m_reset();
        #2;
        chk("rst_lvl1", int'(bus.carga_bateria1), 0);
        chk("rst_total", int'(bus.carga_total), 0);
        chk("rst_baja", int'(bus.bateria_baja), 1);
        chk("rst_carg", int'(bus.cargando), 0);
        chk("rst_comp", int'(bus.completo), 0);
        @(negedge clk); rst_n = 1'b1;

        // Full charge from 0/0 with defaults, counting edges from enable.
        bus.habilitar = 1'b1;
        for (int e = 1; e <= 151; e++) begin
            tick();
            if (e == 2) chk("e2_sel1", int'(bus.sel_bateria), 0);
            if (e == 5) chk("e5_lvl1", int'(bus.carga_bateria1), 0);
            if (e == 6) chk("e6_lvl1", int'(bus.carga_bateria1), 1);
            if (e == 7) chk("e7_sel2", int'(bus.sel_bateria), 1);
            if (e == 150) chk("e150_comp", int'(bus.completo), 0);
            if (e == 151) begin
                chk("e151_comp", int'(bus.completo), 1);
                chk("e151_total", int'(bus.carga_total), 30);
            end
        end

        // Discharge while full: 14/29 on that edge, idle next, refill.
        bus.descarga2 = 1'b1;
        tick();
        bus.descarga2 = 1'b0;
        chk("ll_lvl2", int'(bus.carga_bateria2), 14);
        chk("ll_comp_hold", int'(bus.completo), 1);
        tick();
        chk("ll_exit", int'(bus.completo), 0);
        for (int i = 0; i < 6; i++) tick();
        chk("ll_refill", int'(bus.completo), 1);
        chk("ll_lvl2_15", int'(bus.carga_bateria2), 15);

        // Randomized enable and discharge traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.habilitar = ($urandom_range(0, 9) != 0);
            bus.descarga1 = ($urandom_range(0, 6) == 0);
            bus.descarga2 = ($urandom_range(0, 6) == 0);
            tick();
        end

        // Asynchronous reset in the middle of a charging step.
        bus.descarga1 = 1'b0; bus.descarga2 = 1'b0;
        bus.habilitar = 1'b1;
        guard = 0;
        while (mode != 2 && guard < 50) begin tick(); guard++; end
        chk("reach_carg", int'(mode == 2), 1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst_lvl1", int'(bus.carga_bateria1), 0);
        chk("arst_lvl2", int'(bus.carga_bateria2), 0);
        chk("arst_carg", int'(bus.cargando), 0);
        chk("arst_comp", int'(bus.completo), 0);
        chk("arst_baja", int'(bus.bateria_baja), 1);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
